axi_lite_reg_bank: RTL

AXI_LITE_REG_BANK -- requirements
Module: axi_lite_reg_bank

---
 rtl/axi_lite_reg_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: AXI4-Lite register bank with a user-side write/read port and per-register write pulses
module axi_lite_reg_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter logic [NUMBER_OF_REGISTERS-1:0] RO_MASK = '0
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    input  logic                             usr_wr_en,
    input  logic [7:0]                       usr_wr_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]    usr_wr_data,
    input  logic [7:0]                       usr_rd_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]    usr_rd_data,
    output logic [NUMBER_OF_REGISTERS-1:0]   usr_wr_pulse
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUMBER_OF_REGISTERS];
    logic [IW-1:0] w_idx, r_idx;
    logic [NUMBER_OF_REGISTERS-1:0] w_hit;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_mask, r_val;
    logic r_in, w_fire, r_fire, unused_addr;

    assign w_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign w_fire = (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign r_fire = (r_state == R_IDLE) && S_AXI_ARVALID;
    assign S_AXI_AWREADY = w_fire;
    assign S_AXI_WREADY = w_fire;
    assign S_AXI_BVALID = (w_state == W_RESP);
    assign S_AXI_ARREADY = r_fire;
    assign S_AXI_RVALID = (r_state == R_DATA);

    // address decode: writable target of a write, read mux for AXI and user ports, byte-lane mask
    always_comb begin
        w_hit = '0;
        w_mask = '0;
        r_val = '0;
        r_in = 1'b0;
        usr_rd_data = '0;
        for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
            w_hit[i] = (w_idx == IW'(i)) && !RO_MASK[i];
            if (r_idx == IW'(i)) begin
                r_val = regs[i];
                r_in = 1'b1;
            end
            if (usr_rd_idx == 8'(i)) usr_rd_data = regs[i];
        end
        for (int b = 0; b < NB; b++) w_mask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    end

    // next-state logic for the independent write and read channels
    always_comb begin
        w_next = (w_state == W_IDLE) ? (w_fire ? W_RESP : W_IDLE) : (S_AXI_BREADY ? W_IDLE : W_RESP);
        r_next = (r_state == R_IDLE) ? (r_fire ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
    end

    // state registers, response capture and commit pulses
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            S_AXI_BRESP <= 2'b00;
            S_AXI_RRESP <= 2'b00;
            S_AXI_RDATA <= '0;
            usr_wr_pulse <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            usr_wr_pulse <= w_fire ? w_hit : '0;
            if (w_fire) S_AXI_BRESP <= |w_hit ? 2'b00 : 2'b10;
            if (r_fire) begin
                S_AXI_RDATA <= r_val;
                S_AXI_RRESP <= r_in ? 2'b00 : 2'b10;
            end
        end
    end

    // register storage: an AXI commit overrides a same-cycle user write to the same register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                if (w_fire && w_hit[i]) regs[i] <= (regs[i] & ~w_mask) | (S_AXI_WDATA & w_mask);
                else if (usr_wr_en && usr_wr_idx == 8'(i)) regs[i] <= usr_wr_data;
            end
        end
    end
endmodule
